// File: rtl/ccsds_mod_pkg.sv
// Shared types and elaboration-time constant builders for the CCSDS PSK modulator.
package ccsds_mod_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK = 2'd0,
    MODE_QPSK = 2'd1,
    MODE_8PSK = 2'd2,
    MODE_RSVD = 2'd3
  } mod_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PSK8_POINTS = 8;

  typedef struct packed {
    int i;
    int q;
  } iq_point_t;

  typedef iq_point_t [PSK8_POINTS-1:0] psk8_table_t;

  function automatic mod_mode_e norm_mode(logic [1:0] mode);
    return (mode == 2'd3) ? MODE_QPSK : mod_mode_e'(mode);
  endfunction

  // round(amp / sqrt(2)) using an integer square root of amp^2/2.
  function automatic int round_inv_sqrt2(int amp);
    longint half_sq, root, trial;
    half_sq = (longint'(amp) * longint'(amp)) >> 1;
    root    = 0;
    for (int b = 30; b >= 0; b--) begin
      trial = root + (longint'(1) << b);
      if (trial * trial <= half_sq) root = trial;
    end
    if (((root << 1) + longint'(1)) * ((root << 1) + longint'(1)) <=
        ((longint'(amp) * longint'(amp)) << 1))
      root = root + longint'(1);
    return int'(root);
  endfunction

  function automatic psk8_table_t psk8_table(int iq_width);
    int          amp;
    int          diag;
    psk8_table_t tab;
    amp    = (1 << (iq_width - 1)) - 1;
    diag   = round_inv_sqrt2(amp);
    tab[0] = '{amp, 0};
    tab[1] = '{diag, diag};
    tab[2] = '{0, amp};
    tab[3] = '{-diag, diag};
    tab[4] = '{-amp, 0};
    tab[5] = '{-diag, -diag};
    tab[6] = '{0, -amp};
    tab[7] = '{diag, -diag};
    return tab;
  endfunction

endpackage

// File: rtl/ccsds_psk_mapper.sv
// Combinational symbol mapper: Gray-decodes the symbol bits, applies optional
// differential accumulation and looks up the constellation point.
module ccsds_psk_mapper
  import ccsds_mod_pkg::*;
#(
  parameter int IQ_WIDTH = 13
) (
  input  mod_mode_e                  mode_i,
  input  logic                       diff_en_i,
  input  logic [2:0]                 bits_i,
  input  logic [2:0]                 p_prev_i,
  output logic [2:0]                 p_o,
  output logic signed [IQ_WIDTH-1:0] i_o,
  output logic signed [IQ_WIDTH-1:0] q_o
);

  localparam logic signed [IQ_WIDTH-1:0] AMP  = IQ_WIDTH'((1 << (IQ_WIDTH - 1)) - 1);
  localparam psk8_table_t                PSK8 = psk8_table(IQ_WIDTH);

  logic [2:0] gray_idx;
  logic [2:0] mask;
  logic [2:0] sum;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    gray_idx = 3'd0;
    mask     = 3'd3;
    case (mode_i)
      MODE_BPSK: begin
        gray_idx = {2'b00, bits_i[0]};
        mask     = 3'd1;
      end
      MODE_8PSK: begin
        gray_idx = {bits_i[2], bits_i[2] ^ bits_i[1], ^bits_i};
        mask     = 3'd7;
      end
      default: begin
        // bits_i[0] is the Gray MSB so the legacy sign mapping 01 -> (+,-) holds.
        gray_idx = {1'b0, bits_i[0], bits_i[0] ^ bits_i[1]};
        mask     = 3'd3;
      end
    endcase

    sum = p_prev_i + gray_idx;
    p_o = (diff_en_i ? sum : gray_idx) & mask;

    i_o = AMP;
    q_o = '0;
    case (mode_i)
      MODE_BPSK: begin
        i_o = p_o[0] ? -AMP : AMP;
        q_o = '0;
      end
      MODE_8PSK: begin
        i_o = IQ_WIDTH'(PSK8[p_o].i);
        q_o = IQ_WIDTH'(PSK8[p_o].q);
      end
      default: begin
        i_o = (p_o[0] ^ p_o[1]) ? -AMP : AMP;
        q_o = p_o[1] ? -AMP : AMP;
      end
    endcase
  end

endmodule

// File: rtl/ccsds_psk_modulator.sv
// CCSDS PSK modulator top: run/idle FSM, per-symbol hold counter, differential
// phase accumulator and registered I/Q outputs.
module ccsds_psk_modulator
  import ccsds_mod_pkg::*;
#(
  parameter int IQ_WIDTH  = 13,
  parameter int SPS_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [1:0]                 mode_i,
  input  logic                       diff_en_i,
  input  logic [SPS_WIDTH-1:0]       samples_per_symbol_i,
  input  logic [2:0]                 bits_i,
  input  logic                       bits_valid_i,
  output logic                       bits_ready_o,
  output logic signed [IQ_WIDTH-1:0] i_data_o,
  output logic signed [IQ_WIDTH-1:0] q_data_o,
  output logic                       sample_valid_o,
  output logic                       underrun_o
);

  localparam logic [SPS_WIDTH-1:0] SPS_ONE = SPS_WIDTH'(1);

  state_e                     state_q, state_d;
  mod_mode_e                  mode_q, mode_d, map_mode;
  logic                       diff_q, diff_d, map_diff;
  logic [SPS_WIDTH-1:0]       cnt_q, cnt_d, sps_q, sps_d, sps_eff;
  logic [2:0]                 acc_q, acc_d, map_p;
  logic signed [IQ_WIDTH-1:0] i_q, i_d, q_q, q_d, map_i, map_q;
  logic                       valid_q, valid_d, underrun_q, underrun_d;
  logic                       boundary;

  assign sps_eff      = (samples_per_symbol_i == '0) ? SPS_ONE : samples_per_symbol_i;
  assign boundary     = (state_q == RUN) && (cnt_q == sps_q - SPS_ONE);
  assign bits_ready_o = boundary || (state_q == IDLE);

  // On the start cycle the mapper must see the live mode/diff ports, not the stale latch.
  assign map_mode = (state_q == IDLE) ? norm_mode(mode_i) : mode_q;
  assign map_diff = (state_q == IDLE) ? diff_en_i : diff_q;

  ccsds_psk_mapper #(
    .IQ_WIDTH (IQ_WIDTH)
  ) u_mapper (
    .mode_i    (map_mode),
    .diff_en_i (map_diff),
    .bits_i    (bits_i),
    .p_prev_i  (acc_q),
    .p_o       (map_p),
    .i_o       (map_i),
    .q_o       (map_q)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    sps_d      = sps_q;
    acc_d      = acc_q;
    i_d        = i_q;
    q_d        = q_q;
    valid_d    = valid_q;
    underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        acc_d   = '0;
        i_d     = '0;
        q_d     = '0;
        valid_d = 1'b0;
        if (enable_i && bits_valid_i) begin
          state_d = RUN;
          mode_d  = norm_mode(mode_i);
          diff_d  = diff_en_i;
          sps_d   = sps_eff;
          acc_d   = map_p;
          i_d     = map_i;
          q_d     = map_q;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (!boundary) begin
          cnt_d = cnt_q + SPS_ONE;
        end else if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          i_d     = '0;
          q_d     = '0;
          valid_d = 1'b0;
        end else begin
          cnt_d = '0;
          sps_d = sps_eff;
          if (bits_valid_i) begin
            acc_d = map_p;
            i_d   = map_i;
            q_d   = map_q;
          end else begin
            i_d        = '0;
            q_d        = '0;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every one updates from the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= MODE_QPSK;
      diff_q     <= 1'b0;
      cnt_q      <= '0;
      sps_q      <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      q_q        <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      diff_q     <= diff_d;
      cnt_q      <= cnt_d;
      sps_q      <= sps_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign i_data_o       = i_q;
  assign q_data_o       = q_q;
  assign sample_valid_o = valid_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_ccsds_psk_modulator.sv
// Self-checking bench for ccsds_psk_modulator against a symbol-level reference model.
module tb_ccsds_psk_modulator;

  localparam int  IQW  = 13;
  localparam int  SPSW = 32;
  localparam int  A    = (1 << (IQW - 1)) - 1;
  localparam real PI   = 3.14159265358979;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  enable_i;
  logic [1:0]            mode_i;
  logic                  diff_en_i;
  logic [SPSW-1:0]       samples_per_symbol_i;
  logic [2:0]            bits_i;
  logic                  bits_valid_i;
  logic                  bits_ready_o;
  logic signed [IQW-1:0] i_data_o;
  logic signed [IQW-1:0] q_data_o;
  logic                  sample_valid_o;
  logic                  underrun_o;

  int         tests = 0;
  int         fails = 0;
  logic [2:0] sym_bits [0:31];
  int         gap_slot;

  always #5 clk_i = ~clk_i;

  ccsds_psk_modulator #(
    .IQ_WIDTH  (IQW),
    .SPS_WIDTH (SPSW)
  ) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .enable_i             (enable_i),
    .mode_i               (mode_i),
    .diff_en_i            (diff_en_i),
    .samples_per_symbol_i (samples_per_symbol_i),
    .bits_i               (bits_i),
    .bits_valid_i         (bits_valid_i),
    .bits_ready_o         (bits_ready_o),
    .i_data_o             (i_data_o),
    .q_data_o             (q_data_o),
    .sample_valid_o       (sample_valid_o),
    .underrun_o           (underrun_o)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int order_of(int mode);
    case (mode)
      0:       return 2;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  // Natural phase index of a symbol before any differential accumulation.
  function automatic int natural_index(int mode, logic [2:0] b);
    int qpsk_idx [4];
    int gray_dec [8];
    qpsk_idx = '{0, 3, 1, 2};
    gray_dec = '{0, 1, 3, 2, 7, 6, 4, 5};
    case (mode)
      0:       return int'(b[0]);
      2:       return gray_dec[b];
      default: return qpsk_idx[b[1:0]];
    endcase
  endfunction

  task automatic ref_point(input int mode, input int p, output int ei, output int eq);
    int  qi [4];
    int  qq [4];
    real ang;
    qi = '{A, -A, -A, A};
    qq = '{A, A, -A, -A};
    case (mode)
      0: begin
        ei = (p != 0) ? -A : A;
        eq = 0;
      end
      2: begin
        ang = p * PI / 4.0;
        ei  = rnd(A * $cos(ang));
        eq  = rnd(A * $sin(ang));
      end
      default: begin
        ei = qi[p];
        eq = qq[p];
      end
    endcase
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) sym_bits[i] = 3'($urandom);
  endtask

  // Streams nslots symbol slots from IDLE, then drops enable at the final boundary.
  // rst_at >= 0 asserts reset asynchronously in that output cycle and aborts.
  task automatic run_stream(input int mode, input bit diff, input int sps, input int nslots, input int rst_at);
    int eff, prev, p, ei, eq, slot;
    bit gap;
    eff  = (sps == 0) ? 1 : sps;
    prev = 0;
    ei   = 0;
    eq   = 0;
    gap  = 1'b0;
    for (int k = 0; k <= nslots * eff; k++) begin
      @(negedge clk_i);
      samples_per_symbol_i = SPSW'(sps);
      if (k % eff == 0) begin
        slot         = k / eff;
        enable_i     = (slot < nslots);
        bits_valid_i = (slot != gap_slot);
        bits_i       = sym_bits[slot];
        mode_i       = (k == 0) ? 2'(mode) : 2'($urandom);
        diff_en_i    = (k == 0) ? diff : 1'($urandom);
        #1 check("ready_at_boundary", bits_ready_o, 1);
      end else begin
        enable_i     = 1'b1;
        bits_valid_i = 1'b1;
        bits_i       = 3'($urandom);
        mode_i       = 2'($urandom);
        diff_en_i    = 1'($urandom);
        #1 check("ready_mid_symbol", bits_ready_o, 0);
      end
      @(posedge clk_i);
      #1;
      if (k == nslots * eff) begin
        check("idle_valid", sample_valid_o, 0);
        check("idle_i", i_data_o, 0);
        check("idle_q", q_data_o, 0);
        check("idle_underrun", underrun_o, 0);
      end else begin
        if (k % eff == 0) begin
          slot = k / eff;
          gap  = (slot == gap_slot);
          if (gap) begin
            ei = 0;
            eq = 0;
          end else begin
            p = natural_index(mode, sym_bits[slot]);
            if (diff) p = (prev + p) % order_of(mode);
            prev = p;
            ref_point(mode, p, ei, eq);
          end
        end
        check("run_i", i_data_o, ei);
        check("run_q", q_data_o, eq);
        check("run_valid", sample_valid_o, 1);
        check("run_underrun", underrun_o, (gap && (k % eff == 0)) ? 1 : 0);
        if (k == rst_at) begin
          #2 rst_i = 1'b1;
          #1;
          check("async_rst_i", i_data_o, 0);
          check("async_rst_q", q_data_o, 0);
          check("async_rst_valid", sample_valid_o, 0);
          check("async_rst_underrun", underrun_o, 0);
          check("async_rst_ready", bits_ready_o, 1);
          return;
        end
      end
    end
    enable_i     = 1'b0;
    bits_valid_i = 1'b0;
  endtask

  initial begin
    int m, sps, n;
    rst_i                = 1'b1;
    enable_i             = 1'b0;
    mode_i               = 2'd0;
    diff_en_i            = 1'b0;
    samples_per_symbol_i = '0;
    bits_i               = '0;
    bits_valid_i         = 1'b0;
    gap_slot             = -1;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_i", i_data_o, 0);
    check("reset_q", q_data_o, 0);
    check("reset_valid", sample_valid_o, 0);
    check("reset_underrun", underrun_o, 0);
    check("reset_ready", bits_ready_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // QPSK legacy mapping, sps=4
    sym_bits[0] = 3'b000; sym_bits[1] = 3'b001; sym_bits[2] = 3'b010; sym_bits[3] = 3'b011;
    run_stream(1, 1'b0, 4, 4, -1);

    // BPSK differential, sps=1; upper bits set to confirm they are ignored
    sym_bits[0] = 3'b111; sym_bits[1] = 3'b001; sym_bits[2] = 3'b110; sym_bits[3] = 3'b011;
    run_stream(0, 1'b1, 1, 4, -1);

    // 8PSK Gray walk, sps=2
    sym_bits[0] = 3'b000; sym_bits[1] = 3'b001; sym_bits[2] = 3'b011; sym_bits[3] = 3'b010;
    run_stream(2, 1'b0, 2, 4, -1);

    // QPSK differential underrun at slot 2, sps=3
    fill_random(8);
    gap_slot = 2;
    run_stream(1, 1'b1, 3, 6, -1);

    // sps=0 behaves as 1, with an underrun; then reserved mode as QPSK
    fill_random(10);
    gap_slot = 5;
    run_stream(2, 1'b1, 0, 8, -1);
    gap_slot = -1;
    fill_random(8);
    run_stream(3, 1'b1, 2, 6, -1);

    // Async reset mid-symbol, then a differential restart from accumulator 0
    fill_random(6);
    run_stream(1, 1'b1, 5, 4, 7);
    @(negedge clk_i);
    enable_i     = 1'b0;
    bits_valid_i = 1'b0;
    rst_i        = 1'b0;
    run_stream(1, 1'b1, 5, 4, -1);

    // Randomised streams
    for (int r = 0; r < 8; r++) begin
      m   = $urandom_range(0, 3);
      sps = $urandom_range(0, 4);
      n   = $urandom_range(3, 10);
      fill_random(n + 1);
      gap_slot = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      run_stream(m, 1'($urandom), sps, n, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
